segre_store_buffer_n: RTL and testbench

// - Parametrised N-entry circular store buffer between the TL stage and the data cache.
// - Retires stores in order, forwards store data to younger loads, and drains the oldest entry to the dcache on a valid/ready handshake.
// - Successor of the fixed 2-entry buffer: configurable depth, occupancy count, youngest-match forwarding, conservative overlap detection.

---
 rtl/segre_pkg.sv | 28 ++
 rtl/segre_sb_match.sv | 48 ++++
 rtl/segre_store_buffer_n.sv | 115 +++++++++++
 tb/tb_segre_store_buffer_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and defaults for the segre store buffer.
package segre_pkg;

  localparam int unsigned ADDR_SIZE              = 32;
  localparam int unsigned WORD_SIZE              = 32;
  localparam int unsigned STORE_BUFFER_NUM_ELEMS = 2;

  // Encoded so that a numeric compare orders access sizes.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    SB_MISS,
    SB_HIT,
    SB_TROUBLE
  } sb_lookup_e;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    memop_data_type_e     mtype;
  } sb_entry_t;

endpackage

// File: rtl/segre_sb_match.sv
// Per-entry overlap/match vectors and youngest-first selection for load forwarding.
module segre_sb_match
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH  = STORE_BUFFER_NUM_ELEMS,
  parameter int unsigned ADDR_W = ADDR_SIZE,
  parameter int unsigned DATA_W = WORD_SIZE,
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  memop_data_type_e  entry_type [DEPTH],
  input  logic [PtrW-1:0]   tail,
  input  logic [ADDR_W-1:0] addr,
  input  memop_data_type_e  mtype,
  output sb_lookup_e        result,
  output logic [DATA_W-1:0] data
);

  logic [DEPTH-1:0] overlap;
  logic [DEPTH-1:0] match;
  logic [PtrW-1:0]  idx;

  always_comb begin
    overlap = '0;
    match   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      overlap[i] = valid[i] && (entry_addr[i][ADDR_W-1:2] == addr[ADDR_W-1:2]);
      match[i]   = overlap[i] && (entry_addr[i] == addr) && (mtype <= entry_type[i]);
    end
  end

  // Walk oldest to youngest so the youngest overlapping entry is written last.
  always_comb begin
    result = SB_MISS;
    data   = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PtrW'(k);
      if (overlap[idx]) begin
        result = match[idx] ? SB_HIT : SB_TROUBLE;
        data   = match[idx] ? entry_data[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/segre_store_buffer_n.sv
// N-entry circular store buffer with load forwarding and in-order dcache drain.
// Optional store coalescing into the youngest entry: define SEGRE_SB_COALESCE_EN.
module segre_store_buffer_n
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH  = STORE_BUFFER_NUM_ELEMS,
  parameter int unsigned ADDR_W = ADDR_SIZE,
  parameter int unsigned DATA_W = WORD_SIZE
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   req_store_i,
  input  logic                   req_load_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      data_i,
  input  memop_data_type_e       type_i,
  input  logic                   flush_ready_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   hit_o,
  output logic                   miss_o,
  output logic                   trouble_o,
  output logic [DATA_W-1:0]      data_load_o,
  output logic                   flush_valid_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [DATA_W-1:0]      data_flush_o,
  output memop_data_type_e       type_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  memop_data_type_e  type_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q, youngest;
  logic [CntW-1:0]   count_q;
  logic              push, pop, coalesce;
  sb_lookup_e        lookup;
  logic [DATA_W-1:0] lookup_data;

  assign full_o   = (count_q == CntW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign youngest = tail_q - PtrW'(1);
  assign pop      = !empty_o && flush_ready_i;

`ifdef SEGRE_SB_COALESCE_EN
  // A popping head cannot absorb the store; it must push instead.
  assign coalesce = req_store_i && !empty_o && (addr_q[youngest] == addr_i) &&
                    (type_q[youngest] == type_i) && !(pop && (youngest == head_q));
`else
  assign coalesce = 1'b0;
`endif

  assign push = req_store_i && !full_o && !coalesce;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= data_i;
      type_q[tail_q] <= type_i;
    end else if (coalesce) begin
      data_q[youngest] <= data_i;
    end
  end

  assign flush_valid_o = !empty_o;
  assign addr_o        = flush_valid_o ? addr_q[head_q] : '0;
  assign data_flush_o  = flush_valid_o ? data_q[head_q] : '0;
  assign type_o        = flush_valid_o ? type_q[head_q] : BYTE;

  segre_sb_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match (
    .valid     (valid_q),
    .entry_addr(addr_q),
    .entry_data(data_q),
    .entry_type(type_q),
    .tail      (tail_q),
    .addr      (addr_i),
    .mtype     (type_i),
    .result    (lookup),
    .data      (lookup_data)
  );

  assign hit_o       = req_load_i && (lookup == SB_HIT);
  assign miss_o      = req_load_i && (lookup == SB_MISS);
  assign trouble_o   = req_load_i && (lookup == SB_TROUBLE);
  assign data_load_o = hit_o ? lookup_data : '0;

endmodule

// File: tb/tb_segre_store_buffer_n.sv
// Randomized and directed bench for segre_store_buffer_n against a queue-based model.
module tb_segre_store_buffer_n;
  import segre_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef SEGRE_SB_COALESCE_EN
  localparam int ExpDupCount = 1;
`else
  localparam int ExpDupCount = 2;
`endif

  logic             clk = 1'b0;
  logic             rsn, req_store, req_load, flush_ready;
  logic [31:0]      addr, data;
  memop_data_type_e mtype;
  logic             full, empty, hit, miss, trouble, flush_valid;
  logic [2:0]       count;
  logic [31:0]      data_load, addr_out, data_flush;
  memop_data_type_e type_out;

  segre_store_buffer_n #(
    .DEPTH (DEPTH),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk_i        (clk),
    .rsn_i        (rsn),
    .req_store_i  (req_store),
    .req_load_i   (req_load),
    .addr_i       (addr),
    .data_i       (data),
    .type_i       (mtype),
    .flush_ready_i(flush_ready),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .hit_o        (hit),
    .miss_o       (miss),
    .trouble_o    (trouble),
    .data_load_o  (data_load),
    .flush_valid_o(flush_valid),
    .addr_o       (addr_out),
    .data_flush_o (data_flush),
    .type_o       (type_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      data;
    memop_data_type_e typ;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic obs_hit, obs_miss, obs_trouble;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares every output against the model's view of the current state.
  task automatic model_check();
    logic eh, em, et, found;
    logic [31:0] ed;
    int n;
    n = mq.size();
    eh = 0; em = 0; et = 0; ed = '0; found = 0;
    if (req_load) begin
      for (int i = n - 1; i >= 0 && !found; i--) begin
        if (mq[i].addr[31:2] == addr[31:2]) begin
          found = 1;
          if (mq[i].addr == addr && mtype <= mq[i].typ) begin
            eh = 1;
            ed = mq[i].data;
          end else begin
            et = 1;
          end
        end
      end
      if (!found) em = 1;
    end
    check("count", 64'(count), 64'(n));
    check("full", 64'(full), 64'(n == DEPTH));
    check("empty", 64'(empty), 64'(n == 0));
    check("flush_valid", 64'(flush_valid), 64'(n != 0));
    check("addr_o", 64'(addr_out), n != 0 ? 64'(mq[0].addr) : 64'(0));
    check("data_flush", 64'(data_flush), n != 0 ? 64'(mq[0].data) : 64'(0));
    if (n != 0) check("type_o", 64'(type_out), 64'(mq[0].typ));
    check("hit", 64'(hit), 64'(eh));
    check("miss", 64'(miss), 64'(em));
    check("trouble", 64'(trouble), 64'(et));
    check("data_load", 64'(data_load), 64'(ed));
    obs_hit = hit; obs_miss = miss; obs_trouble = trouble; obs_data = data_load;
  endtask

  task automatic model_update(input bit rst_n, input bit st, input logic [31:0] a,
                              input logic [31:0] d, input memop_data_type_e t, input bit rdy);
    bit pop, push, co;
    if (!rst_n) begin
      mq.delete();
    end else begin
      pop = (mq.size() > 0) && rdy;
      co  = 0;
`ifdef SEGRE_SB_COALESCE_EN
      if (st && mq.size() > 0 && mq[mq.size()-1].addr == a && mq[mq.size()-1].typ == t &&
          !(pop && mq.size() == 1)) co = 1;
`endif
      push = st && (mq.size() < DEPTH) && !co;
      if (co) mq[mq.size()-1].data = d;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{addr: a, data: d, typ: t});
    end
  endtask

  task automatic step(input bit rst_n, input bit st, input bit ld, input logic [31:0] a,
                      input logic [31:0] d, input memop_data_type_e t, input bit rdy);
    rsn = rst_n; req_store = st; req_load = ld; addr = a; data = d; mtype = t;
    flush_ready = rdy;
    #1;
    model_check();
    @(posedge clk);
    model_update(rst_n, st, a, d, t, rdy);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    step(1, 1, 0, a, d, t, 0);
  endtask

  task automatic load(input logic [31:0] a, input memop_data_type_e t);
    step(1, 0, 1, a, '0, t, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, '0, '0, BYTE, 0);
  endtask

  initial begin
    rsn = 0; req_store = 0; req_load = 0; addr = '0; data = '0; mtype = BYTE;
    flush_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_flush_valid", 64'(flush_valid), 64'(0));
    check("rst_addr_o", 64'(addr_out), 64'(0));

    // Basic enqueue and fill.
    step(1, 0, 0, '0, '0, BYTE, 0);
    store(32'h100, 32'hAAAA5555, WORD);
    store(32'h104, 32'h7F, BYTE);
    check("t1_count", 64'(count), 64'(2));
    check("t1_head", 64'(addr_out), 64'h100);
    check("t1_head_data", 64'(data_flush), 64'hAAAA5555);
    store(32'h108, 32'h1, WORD);
    store(32'h10C, 32'h2, WORD);
    check("t1_full", 64'(full), 64'(1));

    // Youngest same-address store forwards.
    do_reset();
    check("t2_rst_flush_valid", 64'(flush_valid), 64'(0));
    store(32'h200, 32'h11, WORD);
    store(32'h200, 32'h22, WORD);
    check("t2_count", 64'(count), 64'(ExpDupCount));
    load(32'h200, WORD);
    check("t2_hit", 64'(obs_hit), 64'(1));
    check("t2_data", 64'(obs_data), 64'h22);

    // Partial overlaps stall, disjoint words miss.
    do_reset();
    store(32'h300, 32'hAB, BYTE);
    load(32'h300, WORD);
    check("t3_trouble_size", 64'(obs_trouble), 64'(1));
    load(32'h301, BYTE);
    check("t3_trouble_addr", 64'(obs_trouble), 64'(1));
    load(32'h400, WORD);
    check("t3_miss", 64'(obs_miss), 64'(1));
    load(32'h300, BYTE);
    check("t3_hit_byte", 64'(obs_hit), 64'(1));
    check("t3_hit_data", 64'(obs_data), 64'hAB);

    // Full buffer drops a store even when the head pops; then wrap the pointers.
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(4 * i), 32'(i), WORD);
    step(1, 1, 0, 32'h600, 32'h66, WORD, 1);
    check("t4_drop_count", 64'(count), 64'(3));
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h700 + 32'(4 * i), 32'h70 + 32'(i), HALF, 1);
    check("t4_wrap_count", 64'(count), 64'(3));
    check("t4_wrap_head", 64'(addr_out), 64'h714);

    // Reset while the head is presented.
    check("t5_pre_valid", 64'(flush_valid), 64'(1));
    do_reset();
    check("t5_empty", 64'(empty), 64'(1));
    check("t5_flush_valid", 64'(flush_valid), 64'(0));

`ifdef SEGRE_SB_COALESCE_EN
    store(32'h500, 32'h1, WORD);
    store(32'h500, 32'h2, WORD);
    check("t6_coal_count", 64'(count), 64'(1));
    check("t6_coal_data", 64'(data_flush), 64'h2);
    do_reset();
`endif

    // Random traffic over a few words so overlaps are frequent.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      memop_data_type_e t;
      t = memop_data_type_e'($urandom_range(0, 2));
      a = 32'h800 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (t == WORD) a[1:0] = 2'b00;
        if (t == HALF) a[0] = 1'b0;
      end
      step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           a, $urandom, t, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
